// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_seq
// Desc     : MIPS EX-stage unit with single-cycle ALU ops and iterative
//            MUL/DIV behind valid/ready handshakes. Define ALU_DIV_EN to
//            build the restoring divider; otherwise DIV/DIVU flag dbz.
// Revision : 1.0
// ============================================================================
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf,
  output logic             dbz
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int MSB   = WIDTH - 1;

  localparam logic [3:0] c_OP_AND  = 4'b0000;
  localparam logic [3:0] c_OP_OR   = 4'b0001;
  localparam logic [3:0] c_OP_ADD  = 4'b0010;
  localparam logic [3:0] c_OP_SLTU = 4'b0011;
  localparam logic [3:0] c_OP_XOR  = 4'b0100;
  localparam logic [3:0] c_OP_SUB  = 4'b0110;
  localparam logic [3:0] c_OP_SLT  = 4'b0111;
  localparam logic [3:0] c_OP_DIV  = 4'b1010;
  localparam logic [3:0] c_OP_DIVU = 4'b1011;
  localparam logic [3:0] c_OP_NOR  = 4'b1100;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MUL  = 3'd2,
`ifdef ALU_DIV_EN
    S_DIV  = 3'd3,
`endif
    S_DONE = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc, r_lo, r_opd;
  logic [WIDTH-1:0] r_result, r_hi;
  logic             r_out_valid, r_zero, r_ovf, r_dbz;

  logic             w_accept, w_is_mul, w_iter_done, w_signed, w_neg_prod;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_sum, w_dif, w_alu_res;
  logic             w_alu_ovf, w_alu_dbz;
  logic [WIDTH:0]   w_mul_sum;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;

  assign in_ready    = (r_state == S_IDLE);
  assign w_accept    = in_valid & in_ready & ~kill;
  assign w_is_mul    = (op[3:1] == 3'b100);
  assign w_iter_done = (r_cnt == CNT_W'(WIDTH));
  assign w_signed    = ~r_op[0];

  // Iterations run on magnitudes; signed ops only negate on the way out.
  assign w_abs_a = (!op[0] && a[MSB]) ? -a : a;
  assign w_abs_b = (!op[0] && b[MSB]) ? -b : b;

  assign w_mul_sum  = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_opd} : '0);
  assign w_prod     = {r_acc, r_lo};
  assign w_neg_prod = w_signed & (r_a[MSB] ^ r_b[MSB]);
  assign w_prod_fix = w_neg_prod ? -w_prod : w_prod;

`ifdef ALU_DIV_EN
  logic             w_is_div, w_ge;
  logic [WIDTH:0]   w_rem_sh, w_diff;
  logic [WIDTH-1:0] w_q_fix, w_r_fix;

  assign w_is_div = (op[3:1] == 3'b101);
  assign w_rem_sh = {r_acc, r_lo[MSB]};
  assign w_diff   = w_rem_sh - {1'b0, r_opd};
  assign w_ge     = ~w_diff[WIDTH];
  assign w_q_fix  = (w_signed && (r_a[MSB] ^ r_b[MSB])) ? -r_lo : r_lo;
  assign w_r_fix  = (w_signed && r_a[MSB]) ? -r_acc : r_acc;
`endif

  assign w_sum = r_a + r_b;
  assign w_dif = r_a - r_b;

  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    w_alu_dbz = 1'b0;
    case (r_op)
      c_OP_AND:  w_alu_res = r_a & r_b;
      c_OP_OR:   w_alu_res = r_a | r_b;
      c_OP_XOR:  w_alu_res = r_a ^ r_b;
      c_OP_NOR:  w_alu_res = ~(r_a | r_b);
      c_OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
      end
      c_OP_SUB: begin
        w_alu_res = w_dif;
        w_alu_ovf = (r_a[MSB] != r_b[MSB]) && (w_dif[MSB] != r_a[MSB]);
      end
      c_OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      c_OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (r_a < r_b)};
      c_OP_DIV, c_OP_DIVU: w_alu_dbz = 1'b1;
      default:   w_alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_mul) w_next = S_MUL;
`ifdef ALU_DIV_EN
          else if (w_is_div) w_next = S_DIV;
`endif
          else w_next = S_EXEC;
        end
      end
      S_EXEC: w_next = kill ? S_IDLE : S_DONE;
      S_MUL: begin
        if (kill) w_next = S_IDLE;
        else if (w_iter_done) w_next = S_DONE;
      end
`ifdef ALU_DIV_EN
      S_DIV: begin
        if (kill) w_next = S_IDLE;
        else if (w_iter_done) w_next = S_DONE;
      end
`endif
      S_DONE: if (kill || out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= '0; r_a <= '0; r_b <= '0; r_cnt <= '0;
      r_acc <= '0; r_lo <= '0; r_opd <= '0;
      r_result <= '0; r_hi <= '0;
      r_out_valid <= 1'b0; r_zero <= 1'b0; r_ovf <= 1'b0; r_dbz <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= op;
            r_a   <= a;
            r_b   <= b;
            r_cnt <= '0;
            r_acc <= '0;
            r_lo  <= w_is_mul ? w_abs_b : w_abs_a;
            r_opd <= w_is_mul ? w_abs_a : w_abs_b;
          end
        end
        S_EXEC: begin
          if (!kill) begin
            r_result    <= w_alu_res;
            r_hi        <= '0;
            r_zero      <= (w_alu_res == '0);
            r_ovf       <= w_alu_ovf;
            r_dbz       <= w_alu_dbz;
            r_out_valid <= 1'b1;
          end
        end
        S_MUL: begin
          if (!kill) begin
            if (w_iter_done) begin
              {r_hi, r_result} <= w_prod_fix;
              r_zero      <= (w_prod_fix[WIDTH-1:0] == '0);
              r_ovf       <= 1'b0;
              r_dbz       <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_acc <= w_mul_sum[WIDTH:1];
              r_lo  <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
`ifdef ALU_DIV_EN
        S_DIV: begin
          if (!kill) begin
            if (w_iter_done) begin
              r_result    <= (r_b == '0) ? '1 : w_q_fix;
              r_hi        <= (r_b == '0) ? r_a : w_r_fix;
              r_zero      <= (r_b != '0) && (w_q_fix == '0);
              r_ovf       <= 1'b0;
              r_dbz       <= (r_b == '0);
              r_out_valid <= 1'b1;
            end else if (r_b == '0) begin
              r_cnt <= CNT_W'(WIDTH);  // zero divisor: skip straight to finalise
            end else begin
              r_acc <= w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
              r_lo  <= {r_lo[WIDTH-2:0], w_ge};
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
`endif
        S_DONE: if (kill || out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign hi        = r_hi;
  assign zero      = r_zero;
  assign ovf       = r_ovf;
  assign dbz       = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// Bench for alu_muldiv_seq (WIDTH=32): directed vector table, multi-cycle
// corner sequences (stall, kill, async reset) and random ops against a model.
module tb_alu_muldiv_seq;
`ifdef ALU_DIV_EN
  localparam bit DE = 1'b1;
`else
  localparam bit DE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result, hi;
  logic        zero, ovf, dbz;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .kill(kill), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .hi(hi), .zero(zero),
    .ovf(ovf), .dbz(dbz)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, r, h;
    logic        z, v, d;
    int          lat;
    int          stall;
  } vec_t;

  localparam int NV = 15;
  vec_t vt[NV];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic straight from the op definitions.
  function automatic void model(input logic [3:0] o, input logic [31:0] x, y,
                                output logic [31:0] r, h, output logic z, v, d,
                                output int lat);
    longint sx, sy, q, rm;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = '0; h = '0; v = 1'b0; d = 1'b0; lat = 1;
    case (o)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0100: r = x ^ y;
      4'b1100: r = ~(x | y);
      4'b0010: begin r = x + y; v = (x[31] == y[31]) && (r[31] != x[31]); end
      4'b0110: begin r = x - y; v = (x[31] != y[31]) && (r[31] != x[31]); end
      4'b0111: r = (sx < sy) ? 32'd1 : 32'd0;
      4'b0011: r = (x < y) ? 32'd1 : 32'd0;
      4'b1000: begin p = sx * sy; h = p[63:32]; r = p[31:0]; lat = 33; end
      4'b1001: begin p = {32'd0, x} * {32'd0, y}; h = p[63:32]; r = p[31:0]; lat = 33; end
      4'b1010, 4'b1011: begin
        if (!DE) d = 1'b1;
        else if (y == 32'd0) begin r = '1; h = x; d = 1'b1; lat = 2; end
        else begin
          lat = 33;
          if (o[0]) begin r = x / y; h = x % y; end
          else begin q = sx / sy; rm = sx % sy; r = q[31:0]; h = rm[31:0]; end
        end
      end
      default: ;
    endcase
    z = (r == 32'd0);
  endfunction

  task automatic run_op(input string nm, input logic [3:0] o, input logic [31:0] x, y,
                        input logic [31:0] er, eh, input logic ez, ev, ed,
                        input int el, input int stall);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({nm, "_busy"}, 64'(in_ready), 64'(0));
    k = 0;
    while (!out_valid && k < 100) begin @(posedge clk); #1; k++; end
    check({nm, "_lat"},  64'(k), 64'(el));
    check({nm, "_res"},  64'(result), 64'(er));
    check({nm, "_hi"},   64'(hi), 64'(eh));
    check({nm, "_zero"}, 64'(zero), 64'(ez));
    check({nm, "_ovf"},  64'(ovf), 64'(ev));
    check({nm, "_dbz"},  64'(dbz), 64'(ed));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({nm, "_hold_v"},   64'(out_valid), 64'(1));
      check({nm, "_hold_res"}, 64'(result), 64'(er));
      check({nm, "_hold_z"},   64'(zero), 64'(ez));
      check({nm, "_hold_rdy"}, 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, "_drop_v"}, 64'(out_valid), 64'(0));
    check({nm, "_idle"},   64'(in_ready), 64'(1));
  endtask

  initial begin
    logic        saw;
    logic [3:0]  ro;
    logic [31:0] ra, rb, mr, mh;
    logic        mz, mv, md;
    int          ml;

    //            op       a             b             result                     hi                      z     v     d     lat            stall
    vt[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000,              32'h0,                  1'b0, 1'b1, 1'b0, 1,             0};
    vt[1]  = '{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF,              32'h0,                  1'b0, 1'b1, 1'b0, 1,             0};
    vt[2]  = '{4'b0110, 32'h00000003, 32'h00000003, 32'h0,                     32'h0,                  1'b1, 1'b0, 1'b0, 1,             5};
    vt[3]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h1,                     32'h0,                  1'b0, 1'b0, 1'b0, 1,             0};
    vt[4]  = '{4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h0,                     32'h0,                  1'b1, 1'b0, 1'b0, 1,             0};
    vt[5]  = '{4'b1100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF,              32'h0,                  1'b0, 1'b0, 1'b0, 1,             0};
    vt[6]  = '{4'b0100, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5,              32'h0,                  1'b0, 1'b0, 1'b0, 1,             0};
    vt[7]  = '{4'b0101, 32'h00000005, 32'h00000003, 32'h0,                     32'h0,                  1'b1, 1'b0, 1'b0, 1,             0};
    vt[8]  = '{4'b1000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1,              32'hFFFFFFFF,           1'b0, 1'b0, 1'b0, 33,            0};
    vt[9]  = '{4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,              32'hFFFFFFFE,           1'b0, 1'b0, 1'b0, 33,            1};
    vt[10] = '{4'b1000, 32'h80000000, 32'h80000000, 32'h0,                     32'h40000000,           1'b1, 1'b0, 1'b0, 33,            0};
    vt[11] = '{4'b1011, 32'd100,      32'd7,        DE ? 32'd14 : 32'd0,       DE ? 32'd2 : 32'd0,     ~DE,  1'b0, ~DE,  DE ? 33 : 1,   0};
    vt[12] = '{4'b1010, 32'hFFFFFFF9, 32'd2,        DE ? 32'hFFFFFFFD : 32'd0, DE ? 32'hFFFFFFFF : 32'd0, ~DE, 1'b0, ~DE, DE ? 33 : 1,   0};
    vt[13] = '{4'b1010, 32'h00001234, 32'd0,        DE ? 32'hFFFFFFFF : 32'd0, DE ? 32'h1234 : 32'd0, ~DE,  1'b0, 1'b1, DE ? 2 : 1,    0};
    vt[14] = '{4'b1010, 32'h80000000, 32'hFFFFFFFF, DE ? 32'h80000000 : 32'd0, 32'h0,                  ~DE,  1'b0, ~DE,  DE ? 33 : 1,   0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_ready", 64'(in_ready), 64'(1));
    check("rst_res",   64'(result), 64'(0));
    check("rst_hi",    64'(hi), 64'(0));
    check("rst_flags", 64'({zero, ovf, dbz}), 64'(0));

    for (int i = 0; i < NV; i++)
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].r, vt[i].h,
             vt[i].z, vt[i].v, vt[i].d, vt[i].lat, vt[i].stall);

    // kill together with in_valid in IDLE: op must not be taken
    op = 4'b0010; a = 32'd1; b = 32'd2; in_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    check("kill_idle_rdy", 64'(in_ready), 64'(1));
    saw = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (out_valid) saw = 1'b1; end
    check("kill_idle_nov", 64'(saw), 64'(0));

    // kill on cycle 10 of MULTU
    op = 4'b1001; a = $urandom; b = $urandom; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_mul_rdy", 64'(in_ready), 64'(1));
    saw = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) saw = 1'b1; end
    check("kill_mul_nov", 64'(saw), 64'(0));

    // kill while holding a result in DONE
    op = 4'b0010; a = 32'd5; b = 32'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("kdone_v",   64'(out_valid), 64'(1));
    check("kdone_res", 64'(result), 64'(11));
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kdone_drop", 64'(out_valid), 64'(0));
    check("kdone_rdy",  64'(in_ready), 64'(1));

    // asynchronous reset pulse mid-op
    op = DE ? 4'b1010 : 4'b1000; a = 32'h1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #2;
    check("arst_v",   64'(out_valid), 64'(0));
    check("arst_res", 64'(result), 64'(0));
    check("arst_hi",  64'(hi), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_rdy", 64'(in_ready), 64'(1));
    saw = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) saw = 1'b1; end
    check("arst_nov", 64'(saw), 64'(0));

    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        default: rb = $urandom;
      endcase
      model(ro, ra, rb, mr, mh, mz, mv, md, ml);
      run_op($sformatf("rnd%0d_op%0h", i, ro), ro, ra, rb, mr, mh, mz, mv, md, ml,
             $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
